sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO that succeeds the dual-clock FIFO for paths where producer and consumer share one clock. It adds an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It also offers a selectable standard (registered-read) or first-word-fall-through read mode. It sits between same-domain pipeline stages as an elastic buffer.

## Interface
Parameters:
- DATA_WIDTH, 8, word width.
- ADDR_WIDTH, 4, depth DEPTH = 2**ADDR_WIDTH.
- AFULL_THRESH, DEPTH-2, ALMOST_FULL asserts when COUNT >= this; legal range 1..DEPTH.
- AEMPTY_THRESH, 2, ALMOST_EMPTY asserts when COUNT <= this; legal range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = standard, 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- W_INC  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- R_INC  in  1  read request (FWFT: pop).
- rd_data  out  DATA_WIDTH  read word.
- RD_VALID  out  1  standard mode: rd_data updated this cycle; FWFT: equals !EMPTY.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- ALMOST_FULL  out  1  COUNT >= AFULL_THRESH.
- ALMOST_EMPTY  out  1  COUNT <= AEMPTY_THRESH.
- COUNT  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- OVERFLOW  out  1  sticky: a write was rejected.
- UNDERFLOW  out  1  sticky: a read was rejected.
- CLR_ERR  in  1  clears OVERFLOW/UNDERFLOW.

## Operation
- Write is accepted iff W_INC && !FULL. The word is stored at wptr, and wptr advances modulo DEPTH.
- Read is accepted iff R_INC && !EMPTY, and rptr advances modulo DEPTH.
- Flags use the registered COUNT only. When FULL, W_INC is rejected even if a read is accepted in the same cycle. When EMPTY, R_INC is rejected even if a write is accepted in the same cycle.
- COUNT update: +1 on a write only, -1 on a read only, unchanged on both or neither.
- A rejected W_INC sets OVERFLOW, and a rejected R_INC sets UNDERFLOW. Neither rejection changes pointers, COUNT or memory.
- CLR_ERR clears both sticky flags on the next edge. If a new error occurs in the same cycle, that flag is set, not cleared.
- Standard mode: an accepted read registers mem[rptr] into rd_data, and RD_VALID is high for exactly that next cycle. rd_data holds its value otherwise.
- FWFT mode: rd_data = mem[rptr] combinationally while !EMPTY. It is undefined while EMPTY. R_INC consumes the displayed word.
- Pointers are ADDR_WIDTH bits and wrap naturally. Full/empty are determined by COUNT, not by pointer comparison.
- Memory contents are not reset.

## Timing
- Reset values: pointers 0, COUNT 0, EMPTY 1, FULL 0, ALMOST_EMPTY 1, ALMOST_FULL 0, rd_data 0, RD_VALID 0, OVERFLOW 0, UNDERFLOW 0.
- rst overrides every other input in the same edge. Reset mid-operation discards all contents, and flags return to reset values on the following cycle.
- Write latency: a write at edge N updates COUNT and flags after edge N. In FWFT mode the word is visible on rd_data in cycle N+1 when the FIFO was empty.
- Standard read latency is 1 cycle: an accepted read at edge M presents data after edge M with RD_VALID high.
- FWFT: after a pop at edge M, the next word is visible immediately after edge M.
- FULL, EMPTY, ALMOST_* and COUNT are all consistent within a cycle (same registered source).
- Back-to-back reads/writes are sustained every cycle, giving 1 word/cycle throughput each side.

## Structure
- Shared package fifo_pkg:
  - Mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1.
  - A depth helper function, also used by the dual-clock FIFO.
- One sub-module, fifo_mem: DEPTH x DATA_WIDTH dual-port array with synchronous write and asynchronous read.
- The top level holds pointers, COUNT, flag logic, error flags and the standard-mode output register.
- Parameter legality is checked at elaboration; illegal thresholds are a fatal error.

## Test plan
- Reset, then write 0x01..0x10 on consecutive cycles (DEPTH 16). Required: FULL after the 16th write, COUNT = 16, ALMOST_FULL asserted at COUNT = 14, EMPTY low.
- From full, a 17th write of 0xAA. Required: rejected, OVERFLOW = 1, COUNT stays 16. Then CLR_ERR one cycle → OVERFLOW = 0.
- Standard mode: read 16 words. Required: rd_data = 0x01..0x10 in order, each with a 1-cycle RD_VALID, and EMPTY after the last read. One more R_INC → UNDERFLOW = 1.
- Hold COUNT = 8, then assert W_INC and R_INC together for 20 cycles with wrap-around. Required: COUNT stays 8 and output order is preserved across the pointer wrap.
- FWFT = 1: write 0x5A to an empty FIFO. Required: rd_data = 0x5A and EMPTY = 0 the cycle after the write; R_INC once → EMPTY = 1.
- Write 5 words, then assert rst for one cycle with W_INC high. Required: COUNT = 0, EMPTY = 1, all flags at reset values, and the write during reset is discarded.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and depth helper,
// common to the single- and dual-clock FIFOs.
package fifo_pkg;

   localparam bit FIFO_MODE_STD  = 1'b0;
   localparam bit FIFO_MODE_FWFT = 1'b1;

   function automatic int unsigned fifo_depth(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bus of the single-clock FIFO.
// The master side is the user, and the slave side is the FIFO.
interface sync_fifo_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
);
   logic                  W_INC;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  R_INC;
   logic                  CLR_ERR;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  RD_VALID;
   logic                  FULL;
   logic                  EMPTY;
   logic                  ALMOST_FULL;
   logic                  ALMOST_EMPTY;
   logic [ADDR_WIDTH:0]   COUNT;
   logic                  OVERFLOW;
   logic                  UNDERFLOW;

   modport master (
      output W_INC, wr_data, R_INC, CLR_ERR,
      input  rd_data, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
             COUNT, OVERFLOW, UNDERFLOW
   );

   modport slave (
      input  W_INC, wr_data, R_INC, CLR_ERR,
      output rd_data, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
             COUNT, OVERFLOW, UNDERFLOW
   );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage with a synchronous write port and an
// asynchronous read port. Contents are not reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data_c
);
   localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data_c = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, and a standard or first-word-fall-through read mode.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDR_WIDTH    = 4,
   parameter int unsigned AFULL_THRESH  = fifo_depth(ADDR_WIDTH) - 2,
   parameter int unsigned AEMPTY_THRESH = 2,
   parameter bit          FWFT          = FIFO_MODE_STD
) (
   input  logic       clk,
   input  logic       rst,
   sync_fifo_if.slave bus
);
   localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
   localparam int unsigned CW    = ADDR_WIDTH + 1;

   if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
      $fatal(1, "sync_fifo: AFULL_THRESH out of range 1..DEPTH");
   end
   if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
      $fatal(1, "sync_fifo: AEMPTY_THRESH out of range 0..DEPTH-1");
   end

   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [CW-1:0]         r_count;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_afull;
   logic                  r_aempty;
   logic                  r_ovf;
   logic                  r_unf;

   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic [CW-1:0]         w_count_nxt;
   logic [DATA_WIDTH-1:0] w_mem_rd;

   // Acceptance looks only at the registered flags, so a same-cycle pop never frees a slot.
   assign w_wr_acc = bus.W_INC && !r_full;
   assign w_rd_acc = bus.R_INC && !r_empty;

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr_acc && !w_rd_acc)      w_count_nxt = r_count + CW'(1);
      else if (!w_wr_acc && w_rd_acc) w_count_nxt = r_count - CW'(1);
   end

   // The flags are computed from the next count, so they stay aligned with COUNT in every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + ADDR_WIDTH'(1);
         if (w_rd_acc) r_rptr <= r_rptr + ADDR_WIDTH'(1);
         r_count  <= w_count_nxt;
         r_full   <= (w_count_nxt == CW'(DEPTH));
         r_empty  <= (w_count_nxt == '0);
         r_afull  <= (w_count_nxt >= CW'(AFULL_THRESH));
         r_aempty <= (w_count_nxt <= CW'(AEMPTY_THRESH));
         r_ovf    <= (bus.W_INC && r_full)  || (r_ovf && !bus.CLR_ERR);
         r_unf    <= (bus.R_INC && r_empty) || (r_unf && !bus.CLR_ERR);
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk         (clk),
      .i_wr_en     (w_wr_acc && !rst),
      .i_wr_addr   (r_wptr),
      .i_wr_data   (bus.wr_data),
      .i_rd_addr   (r_rptr),
      .o_rd_data_c (w_mem_rd)
   );

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // The head word is shown while data is held. Zero is driven when empty to keep the output deterministic.
      assign bus.rd_data  = r_empty ? '0 : w_mem_rd;
      assign bus.RD_VALID = !r_empty;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] r_rd_data;
      logic                  r_rd_valid;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
         end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) r_rd_data <= w_mem_rd;
         end
      end

      assign bus.rd_data  = r_rd_data;
      assign bus.RD_VALID = r_rd_valid;
   end

   assign bus.COUNT        = r_count;
   assign bus.FULL         = r_full;
   assign bus.EMPTY        = r_empty;
   assign bus.ALMOST_FULL  = r_afull;
   assign bus.ALMOST_EMPTY = r_aempty;
   assign bus.OVERFLOW     = r_ovf;
   assign bus.UNDERFLOW    = r_unf;

endmodule

// File: tb/tb_sync_fifo.sv
// Runs a standard-mode FIFO and an FWFT FIFO side by side on one stimulus stream.
// Both are checked every cycle against a queue model, with literal expectations at key points.
module tb_sync_fifo;
   import fifo_pkg::*;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AF_TH = 14;
   localparam int unsigned AE_TH = 2;

   logic clk;
   logic rst;
   int   n_cmp = 0;
   int   n_mis = 0;
   bit   chk_en = 1'b0;

   sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_if_std ();
   sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_if_fwft ();

   sync_fifo #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF_TH),
      .AEMPTY_THRESH(AE_TH), .FWFT(FIFO_MODE_STD)
   ) u_std (.clk(clk), .rst(rst), .bus(u_if_std));

   sync_fifo #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF_TH),
      .AEMPTY_THRESH(AE_TH), .FWFT(FIFO_MODE_FWFT)
   ) u_fwft (.clk(clk), .rst(rst), .bus(u_if_fwft));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model
   logic [DW-1:0] m_q[$];
   bit            m_ovf = 1'b0;
   bit            m_unf = 1'b0;
   bit            m_std_v = 1'b0;
   logic [DW-1:0] m_std_d = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit w, input logic [DW-1:0] d, input bit r,
                             input bit clr, input bit rs);
      bit was_full;
      bit was_empty;
      if (rs) begin
         m_q.delete();
         m_ovf = 1'b0; m_unf = 1'b0; m_std_v = 1'b0; m_std_d = '0;
      end else begin
         was_full  = (m_q.size() == DEPTH);
         was_empty = (m_q.size() == 0);
         m_std_v = r && !was_empty;
         if (r && !was_empty) m_std_d = m_q.pop_front();
         if (w && !was_full) m_q.push_back(d);
         m_ovf = (w && was_full)  || (m_ovf && !clr);
         m_unf = (r && was_empty) || (m_unf && !clr);
      end
   endtask

   task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r,
                        input bit clr, input bit rs);
      rst = rs;
      u_if_std.W_INC  = w; u_if_std.wr_data  = d; u_if_std.R_INC  = r; u_if_std.CLR_ERR  = clr;
      u_if_fwft.W_INC = w; u_if_fwft.wr_data = d; u_if_fwft.R_INC = r; u_if_fwft.CLR_ERR = clr;
      @(posedge clk);
      model_step(w, d, r, clr, rs);
      @(negedge clk);
      #1;
   endtask

   // Per-cycle comparison of both DUTs against the model
   always @(negedge clk) begin
      int n;
      if (chk_en) begin
         n = m_q.size();
         check("std.COUNT",  32'(u_if_std.COUNT),  32'(n));
         check("fwft.COUNT", 32'(u_if_fwft.COUNT), 32'(n));
         check("std.FULL",   32'(u_if_std.FULL),   32'(n == DEPTH));
         check("fwft.FULL",  32'(u_if_fwft.FULL),  32'(n == DEPTH));
         check("std.EMPTY",  32'(u_if_std.EMPTY),  32'(n == 0));
         check("fwft.EMPTY", 32'(u_if_fwft.EMPTY), 32'(n == 0));
         check("std.AFULL",  32'(u_if_std.ALMOST_FULL),   32'(n >= AF_TH));
         check("fwft.AFULL", 32'(u_if_fwft.ALMOST_FULL),  32'(n >= AF_TH));
         check("std.AEMPTY", 32'(u_if_std.ALMOST_EMPTY),  32'(n <= AE_TH));
         check("fwft.AEMPTY",32'(u_if_fwft.ALMOST_EMPTY), 32'(n <= AE_TH));
         check("std.OVF",    32'(u_if_std.OVERFLOW),  32'(m_ovf));
         check("fwft.OVF",   32'(u_if_fwft.OVERFLOW), 32'(m_ovf));
         check("std.UNF",    32'(u_if_std.UNDERFLOW),  32'(m_unf));
         check("fwft.UNF",   32'(u_if_fwft.UNDERFLOW), 32'(m_unf));
         check("std.RD_VALID", 32'(u_if_std.RD_VALID), 32'(m_std_v));
         check("std.rd_data",  32'(u_if_std.rd_data),  32'(m_std_d));
         check("fwft.RD_VALID", 32'(u_if_fwft.RD_VALID), 32'(n != 0));
         if (n != 0) check("fwft.rd_data", 32'(u_if_fwft.rd_data), 32'(m_q[0]));
      end
   end

   initial begin
      rst = 1'b1;
      u_if_std.W_INC = 1'b0;  u_if_std.wr_data = '0;  u_if_std.R_INC = 1'b0;  u_if_std.CLR_ERR = 1'b0;
      u_if_fwft.W_INC = 1'b0; u_if_fwft.wr_data = '0; u_if_fwft.R_INC = 1'b0; u_if_fwft.CLR_ERR = 1'b0;

      cycle(0, 8'h00, 0, 0, 1);
      cycle(0, 8'h00, 0, 0, 1);
      chk_en = 1'b1;
      cycle(0, 8'h00, 0, 0, 0);
      check("reset COUNT",   32'(u_if_std.COUNT), 32'd0);
      check("reset EMPTY",   32'(u_if_std.EMPTY), 32'd1);
      check("reset AEMPTY",  32'(u_if_std.ALMOST_EMPTY), 32'd1);
      check("reset rd_data", 32'(u_if_std.rd_data), 32'd0);

      // Fill to full with 0x01..0x10
      for (int i = 0; i < 16; i++) begin
         cycle(1, DW'(i + 1), 0, 0, 0);
         if (i == 12) check("AFULL at 13", 32'(u_if_std.ALMOST_FULL), 32'd0);
         if (i == 13) check("AFULL at 14", 32'(u_if_std.ALMOST_FULL), 32'd1);
      end
      check("full COUNT", 32'(u_if_std.COUNT), 32'd16);
      check("full FULL",  32'(u_if_std.FULL),  32'd1);
      check("full EMPTY", 32'(u_if_fwft.EMPTY), 32'd0);

      cycle(1, 8'hAA, 0, 0, 0);
      check("overflow OVF",   32'(u_if_std.OVERFLOW), 32'd1);
      check("overflow COUNT", 32'(u_if_std.COUNT),    32'd16);
      cycle(0, 8'h00, 0, 1, 0);
      check("clr OVF", 32'(u_if_std.OVERFLOW), 32'd0);

      // Drain in order
      for (int i = 0; i < 16; i++) begin
         check("fwft head", 32'(u_if_fwft.rd_data), 32'(i + 1));
         cycle(0, 8'h00, 1, 0, 0);
         check("std read data",  32'(u_if_std.rd_data),  32'(i + 1));
         check("std read valid", 32'(u_if_std.RD_VALID), 32'd1);
      end
      check("drained EMPTY", 32'(u_if_std.EMPTY), 32'd1);
      cycle(0, 8'h00, 0, 0, 0);
      check("valid one cycle", 32'(u_if_std.RD_VALID), 32'd0);
      cycle(0, 8'h00, 1, 0, 0);
      check("underflow UNF", 32'(u_if_std.UNDERFLOW), 32'd1);
      cycle(0, 8'h00, 0, 1, 0);

      // Hold 8 words, then stream through pointer wrap
      for (int i = 0; i < 8; i++) cycle(1, DW'(8'h20 + i), 0, 0, 0);
      for (int i = 0; i < 20; i++) cycle(1, DW'(8'h80 + i), 1, 0, 0);
      check("stream COUNT", 32'(u_if_std.COUNT), 32'd8);
      check("stream order", 32'(u_if_std.rd_data), 32'h8b);
      for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1, 0, 0);

      // FWFT fall-through
      cycle(1, 8'h5A, 0, 0, 0);
      check("fwft 5A data",  32'(u_if_fwft.rd_data), 32'h5A);
      check("fwft 5A EMPTY", 32'(u_if_fwft.EMPTY),   32'd0);
      cycle(0, 8'h00, 1, 0, 0);
      check("fwft pop EMPTY", 32'(u_if_fwft.EMPTY), 32'd1);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         cycle(bit'($urandom_range(0, 99) < 55), DW'($urandom_range(0, 255)),
               bit'($urandom_range(0, 99) < 50), bit'($urandom_range(0, 99) < 5),
               bit'($urandom_range(0, 199) == 0));
      end

      // Reset mid-operation with a write request pending
      cycle(0, 8'h00, 0, 1, 1);
      for (int i = 0; i < 5; i++) cycle(1, DW'(8'h40 + i), 0, 0, 0);
      cycle(1, 8'h77, 0, 0, 1);
      check("rst COUNT",  32'(u_if_std.COUNT),        32'd0);
      check("rst EMPTY",  32'(u_if_std.EMPTY),        32'd1);
      check("rst FULL",   32'(u_if_std.FULL),         32'd0);
      check("rst AFULL",  32'(u_if_std.ALMOST_FULL),  32'd0);
      check("rst AEMPTY", 32'(u_if_fwft.ALMOST_EMPTY), 32'd1);
      check("rst OVF",    32'(u_if_std.OVERFLOW),     32'd0);
      check("rst UNF",    32'(u_if_std.UNDERFLOW),    32'd0);
      check("rst VALID",  32'(u_if_std.RD_VALID),     32'd0);
      cycle(0, 8'h00, 0, 0, 0);
      check("rst write discarded", 32'(u_if_fwft.COUNT), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
